// File: rtl/fwft_word_packer_if.sv
// Handshake bundle for fwft_word_packer: FWFT read side plus the packed-word output port.
// The flush/out_nbytes pair exists only when FWFT_PACK_FLUSH_EN is defined.
interface fwft_word_packer_if #(
    parameter int NBYTES = 4
);
    logic                  empty;
    logic [7:0]            rd_data;
    logic                  rd_enable;
    logic [8*NBYTES-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;

`ifdef FWFT_PACK_FLUSH_EN
    localparam int NBW = $clog2(NBYTES) + 1;

    logic                  flush;
    logic [NBW-1:0]        out_nbytes;

    modport master (
        input  empty,
        input  rd_data,
        output rd_enable,
        output out_data,
        output out_valid,
        input  out_ready,
        input  flush,
        output out_nbytes
    );

    modport slave (
        output empty,
        output rd_data,
        input  rd_enable,
        input  out_data,
        input  out_valid,
        output out_ready,
        output flush,
        input  out_nbytes
    );
`else
    modport master (
        input  empty,
        input  rd_data,
        output rd_enable,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output empty,
        output rd_data,
        input  rd_enable,
        input  out_data,
        input  out_valid,
        output out_ready
    );
`endif
endinterface

// File: rtl/fwft_word_packer.sv
// FWFT byte-to-word packer: drains an 8-bit first-word-fall-through FIFO and emits NBYTES-wide
// little-endian words on a valid/ready port. Optional partial-word flush: FWFT_PACK_FLUSH_EN.
module fwft_word_packer #(
    parameter int NBYTES = 4,
    parameter int CNTW   = 16
) (
    input  logic               rclk,
    input  logic               rrst_n,
    fwft_word_packer_if.master bus,
    output logic [CNTW-1:0]    word_cnt
);
    localparam int NBW = $clog2(NBYTES) + 1;

    logic [NBW-1:0]         cnt;
    logic [NBYTES-1:0][7:0] acc;
    logic [NBYTES-1:0][7:0] acc_nxt;
    logic [8*NBYTES-1:0]    out_data_q;
    logic                   out_valid_q;
    logic                   last;
    logic                   slot_free;
    logic                   accept;
    logic                   load_full;
    logic                   handoff;
    logic                   flush_pend;
    logic                   flush_emit;

    assign last      = (cnt == NBW'(NBYTES - 1));
    assign slot_free = ~out_valid_q | bus.out_ready;
    // out_ready feeds the pop request directly so a word can hand off and refill in one cycle
    assign accept    = ~bus.empty & ~flush_pend & (~last | slot_free);
    assign load_full = accept & last;
    assign handoff   = out_valid_q & bus.out_ready;

    assign bus.rd_enable = accept;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt == NBW'(i)) begin
                acc_nxt[i] = bus.rd_data;
            end
        end
    end

`ifdef FWFT_PACK_FLUSH_EN
    logic           flush_set;
    logic [NBW-1:0] out_nbytes_q;

    // a byte accepted alongside the flush is counted in the partial word; a completing byte wins
    assign flush_set  = bus.flush & ~flush_pend & ~load_full & ((cnt != '0) | accept);
    assign flush_emit = flush_pend & slot_free;
    assign bus.out_nbytes = out_nbytes_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            flush_pend   <= 1'b0;
            out_nbytes_q <= '0;
        end else begin
            if (flush_emit) begin
                flush_pend <= 1'b0;
            end else if (flush_set) begin
                flush_pend <= 1'b1;
            end

            if (load_full) begin
                out_nbytes_q <= NBW'(NBYTES);
            end else if (flush_emit) begin
                out_nbytes_q <= cnt;
            end
        end
    end
`else
    assign flush_pend = 1'b0;
    assign flush_emit = 1'b0;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc         <= '0;
            cnt         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt    <= '0;
        end else begin
            if (load_full) begin
                out_data_q <= acc_nxt;
                acc        <= '0;
                cnt        <= '0;
            end else if (flush_emit) begin
                // unused upper lanes are already zero since acc clears on every emit
                out_data_q <= acc;
                acc        <= '0;
                cnt        <= '0;
            end else if (accept) begin
                acc <= acc_nxt;
                cnt <= cnt + NBW'(1);
            end

            if (load_full || flush_emit) begin
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (handoff) begin
                word_cnt <= word_cnt + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fwft_word_packer.sv
// Self-checking bench for fwft_word_packer: FWFT byte queue model plus a word scoreboard
// built by grouping consumed bytes in order.
module tb_fwft_word_packer;
    localparam int NB  = 4;
    localparam int CW  = 10;
    localparam int NBW = $clog2(NB) + 1;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [CW-1:0] word_cnt;

    fwft_word_packer_if #(.NBYTES(NB)) bus();

    fwft_word_packer #(.NBYTES(NB), .CNTW(CW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .bus      (bus),
        .word_cnt (word_cnt)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int failures = 0;

    byte unsigned    fifo_q[$];
    byte unsigned    part[$];
    logic [8*NB-1:0] exp_q[$];
    int              exp_n_q[$];
    int              model_cnt = 0;
    bit              gap = 1'b0;

    bit              s_pop, s_hs, s_empty, s_flush;
    logic [8*NB-1:0] s_data;
    logic [NBW-1:0]  s_nb;

    task automatic drive_fifo();
        bus.empty   = gap || (fifo_q.size() == 0);
        bus.rd_data = bus.empty ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic push_byte(input byte unsigned b);
        fifo_q.push_back(b);
        drive_fifo();
    endtask

    task automatic emit_part();
        logic [8*NB-1:0] w;
        w = '0;
        for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
        exp_q.push_back(w);
        exp_n_q.push_back(part.size());
        part.delete();
    endtask

    // one clock: sample just before the edge, update the model, check, redrive at negedge
    task automatic tick();
        logic [8*NB-1:0] w;
        int              n;
        @(posedge rclk);
        s_pop   = bus.rd_enable;
        s_hs    = bus.out_valid & bus.out_ready;
        s_data  = bus.out_data;
        s_empty = bus.empty;
        s_flush = 1'b0;
        s_nb    = '0;
`ifdef FWFT_PACK_FLUSH_EN
        s_flush = bus.flush;
        s_nb    = bus.out_nbytes;
`endif
        @(negedge rclk);
        if (s_pop) begin
            checks++;
            if (s_empty) begin
                failures++;
                $display("FAIL pop_while_empty rd_enable=1 empty=%0b required rd_enable=0", s_empty);
            end else begin
                part.push_back(fifo_q.pop_front());
                if (part.size() == NB) emit_part();
            end
        end
        if (s_flush && part.size() > 0) emit_part();
        if (s_hs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got=%h required none", s_data);
            end else begin
                w = exp_q.pop_front();
                n = exp_n_q.pop_front();
                if (s_data !== w) begin
                    failures++;
                    $display("FAIL word_data got=%h required=%h", s_data, w);
                end
`ifdef FWFT_PACK_FLUSH_EN
                checks++;
                if (s_nb !== NBW'(n)) begin
                    failures++;
                    $display("FAIL out_nbytes got=%0d required=%0d", s_nb, n);
                end
`endif
            end
            model_cnt++;
        end
        checks++;
        if (word_cnt !== CW'(model_cnt)) begin
            failures++;
            $display("FAIL word_cnt got=%0d required=%0d", word_cnt, CW'(model_cnt));
        end
        drive_fifo();
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        fifo_q.delete();
        part.delete();
        exp_q.delete();
        exp_n_q.delete();
        model_cnt = 0;
        gap = 1'b0;
        bus.out_ready = 1'b0;
`ifdef FWFT_PACK_FLUSH_EN
        bus.flush = 1'b0;
`endif
        drive_fifo();
        repeat (2) @(negedge rclk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || word_cnt !== '0 || bus.rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b data=%h cnt=%0d rd_en=%b required 0/0/0/0",
                     bus.out_valid, bus.out_data, word_cnt, bus.rd_enable);
        end
`ifdef FWFT_PACK_FLUSH_EN
        checks++;
        if (bus.out_nbytes !== '0) begin
            failures++;
            $display("FAIL reset_nbytes got=%0d required=0", bus.out_nbytes);
        end
`endif
        rrst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_word();
        int npop = 0, first = -1, lastc = -1;
        bus.out_ready = 1'b1;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_pop) begin
                npop++;
                if (first < 0) first = i;
                lastc = i;
                if (npop == 4) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
                        failures++;
                        $display("FAIL single_word valid=%b data=%h required 1/44332211",
                                 bus.out_valid, bus.out_data);
                    end
                end
            end
        end
        checks++;
        if (npop != 4 || lastc - first != 3) begin
            failures++;
            $display("FAIL single_pops got=%0d span=%0d required 4/3", npop, lastc - first);
        end
        checks++;
        if (word_cnt !== CW'(1)) begin
            failures++;
            $display("FAIL single_word_cnt got=%0d required=1", word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int npop = 0, first = -1, lastc = -1, nhs = 0;
        int hs_at[3];
        bus.out_ready = 1'b1;
        for (int b = 0; b < 12; b++) push_byte(8'(b));
        for (int i = 0; i < 18; i++) begin
            tick();
            if (s_pop) begin
                npop++;
                if (first < 0) first = i;
                lastc = i;
            end
            if (s_hs) begin
                if (nhs < 3) hs_at[nhs] = i;
                nhs++;
            end
        end
        checks++;
        if (npop != 12 || lastc - first != 11) begin
            failures++;
            $display("FAIL b2b_pops got=%0d span=%0d required 12/11", npop, lastc - first);
        end
        checks++;
        if (nhs != 3 || hs_at[1] - hs_at[0] != NB || hs_at[2] - hs_at[1] != NB) begin
            failures++;
            $display("FAIL b2b_spacing words=%0d gaps=%0d,%0d required 3/4,4",
                     nhs, hs_at[1] - hs_at[0], hs_at[2] - hs_at[1]);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int b = 0; b < 8; b++) push_byte(8'(b));
        repeat (10) tick();
        checks++;
        if (fifo_q.size() != 1 || bus.rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall left=%0d rd_en=%b required 1/0", fifo_q.size(), bus.rd_enable);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h03020100) begin
            failures++;
            $display("FAIL bp_hold valid=%b data=%h required 1/03020100", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.rd_enable !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_comb rd_en=%b required 1", bus.rd_enable);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h07060504) begin
            failures++;
            $display("FAIL bp_reload valid=%b data=%h required 1/07060504", bus.out_valid, bus.out_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_empty_gap();
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        push_byte(8'hAA); push_byte(8'hBB);
        repeat (3) tick();
        gap = 1'b1;
        push_byte(8'hCC); push_byte(8'hDD);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.rd_enable !== 1'b0) begin
                failures++;
                $display("FAIL gap_rd_enable cycle=%0d got=%b required 0", i, bus.rd_enable);
            end
            tick();
        end
        gap = 1'b0;
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (bus.out_data !== 32'hDDCCBBAA) begin
                    failures++;
                    $display("FAIL gap_word got=%h required=ddccbbaa", bus.out_data);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL gap_word_timeout got none required ddccbbaa");
        end
    endtask

    task automatic test_reset_midword();
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        push_byte(8'hE1); push_byte(8'hE2);
        repeat (2) tick();
        do_reset();
        bus.out_ready = 1'b1;
        for (int b = 1; b <= 4; b++) push_byte(8'(b));
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (bus.out_data !== 32'h04030201) begin
                    failures++;
                    $display("FAIL rst_mid_word got=%h required=04030201", bus.out_data);
                end
            end
        end
        checks++;
        if (!seen || model_cnt != 1) begin
            failures++;
            $display("FAIL rst_mid_count seen=%0b words=%0d required 1/1", seen, model_cnt);
        end
    endtask

`ifdef FWFT_PACK_FLUSH_EN
    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive_fifo();
        repeat (2) tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle valid=%b required 0", bus.out_valid);
        end
        push_byte(8'hA1); push_byte(8'hB2);
        repeat (2) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        push_byte(8'hC3);
        #1;
        checks++;
        if (bus.rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL flush_pend_rd got=%b required 0", bus.rd_enable);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000B2A1 || bus.out_nbytes !== NBW'(2)) begin
            failures++;
            $display("FAIL flush_word valid=%b data=%h nb=%0d required 1/0000b2a1/2",
                     bus.out_valid, bus.out_data, bus.out_nbytes);
        end
        bus.out_ready = 1'b1;
        repeat (4) tick();
        for (int b = 0; b < 3; b++) push_byte(8'hD0 + 8'(b));
        repeat (6) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (3) tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            gap = ($urandom_range(0, 3) == 0);
`ifdef FWFT_PACK_FLUSH_EN
            bus.flush = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
            drive_fifo();
            tick();
        end
        bus.out_ready = 1'b1;
        gap = 1'b0;
`ifdef FWFT_PACK_FLUSH_EN
        bus.flush = 1'b0;
`endif
        drive_fifo();
        repeat (40) tick();
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_drain left=%0d pending=%0d valid=%b required 0/0/0",
                     fifo_q.size(), exp_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        int budget;
        do_reset();
        bus.out_ready = 1'b1;
        for (int b = 0; b < NB * (1 << CW); b++) fifo_q.push_back(8'($urandom));
        drive_fifo();
        budget = NB * (1 << CW) + 20;
        while (model_cnt < (1 << CW) && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (model_cnt != (1 << CW) || word_cnt !== '0) begin
            failures++;
            $display("FAIL wrap words=%0d word_cnt=%0d required %0d/0", model_cnt, word_cnt, 1 << CW);
        end
    endtask

    initial begin
        bus.empty     = 1'b1;
        bus.rd_data   = '0;
        bus.out_ready = 1'b0;
`ifdef FWFT_PACK_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_empty_gap();
        test_reset_midword();
`ifdef FWFT_PACK_FLUSH_EN
        test_flush();
`endif
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
